// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl
// Fetch-stage program counter controller with a direct-mapped branch
// history table (BHT). It sequences the fetch PC, predicts the next PC from
// the table, redirects on decode-stage mispredictions and trains the table
// with resolved branch outcomes.
//
// Ports
//   clk             single clock, all state changes on its rising edge
//   rst             synchronous active-high reset
//   stall           hold the fetch PC (pipeline frozen)
//   d_valid         decode stage holds a valid instruction
//   d_pc            word PC of the decode instruction
//   d_nextpc        resolved next PC from decode
//   d_fail_predict  decode reports a misprediction
//   d_is_branch     decode instruction is a conditional branch or JAL
//   d_taken         resolved direction of the decode instruction
//   pc              current fetch word PC
//   pc_predicted    predicted next PC for the instruction at pc
//   fetch_valid     instruction fetched at pc is valid
//   flush           kill the wrong-path instruction in fetch/decode
//   mispredict_cnt  saturating misprediction counter
module fetch_pc_ctrl #(
    parameter int BHT_IDX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        d_valid,
    input  logic [12:0] d_pc,
    input  logic [12:0] d_nextpc,
    input  logic        d_fail_predict,
    input  logic        d_is_branch,
    input  logic        d_taken,
    output logic [12:0] pc,
    output logic [12:0] pc_predicted,
    output logic        fetch_valid,
    output logic        flush,
    output logic [15:0] mispredict_cnt
);

    localparam int ENTRIES = 1 << BHT_IDX;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [BHT_IDX-1:0] idx_q, idx_d;
    logic [12:0]        pc_q, pc_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               hold_q, hold_d;

    logic               valid_q [ENTRIES];
    logic [1:0]         ctr_q   [ENTRIES];
    logic [12:0]        tgt_q   [ENTRIES];

    logic [BHT_IDX-1:0] look_idx;
    logic [BHT_IDX-1:0] upd_idx;
    logic [12:0]        pc_inc;
    logic               redirect;
    logic               upd_en;

    logic               wr_en;
    logic [BHT_IDX-1:0] wr_idx;
    logic               wr_valid;
    logic [1:0]         wr_ctr;
    logic               wr_tgt_en;
    logic [12:0]        wr_tgt;

    // Only the low PC bits index the table; the upper decode PC bits are
    // intentionally unused (aliasing entries share a slot).
    logic               unused_d_pc_hi;
    assign unused_d_pc_hi = ^d_pc[12:BHT_IDX];

    assign look_idx       = pc_q[BHT_IDX-1:0];
    assign upd_idx        = d_pc[BHT_IDX-1:0];
    assign pc             = pc_q;
    assign mispredict_cnt = cnt_q;

    // Prediction reads the registered table, so an update to the same entry
    // in this cycle is not visible until the following cycle. While the
    // table is being cleared (or reset is held) the entry under pc may
    // still hold stale data, so the sequential PC is forced.
    always_comb begin
        pc_inc       = pc_q + 13'd1;
        pc_predicted = pc_inc;
        if (rst || state_q == INIT) begin
            pc_predicted = 13'd1;
        end else if (valid_q[look_idx] && ctr_q[look_idx][1]) begin
            pc_predicted = tgt_q[look_idx];
        end
    end

    // Control FSM: INIT walks the index counter over every table entry,
    // RUN sequences the PC. A redirect wins over stall; a redirect taken
    // while stalled costs one bubble on the following cycle (hold_q).
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        hold_d      = 1'b0;
        redirect    = 1'b0;
        upd_en      = 1'b0;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        if (state_q == INIT) begin
            idx_d = idx_q + 1'b1;
            pc_d  = 13'd0;
            if (idx_q == {BHT_IDX{1'b1}}) begin
                state_d = RUN;
            end
        end else begin
            redirect    = d_valid & d_fail_predict;
            flush       = redirect & ~rst;
            fetch_valid = ~hold_q & ~rst;
            upd_en      = d_valid & d_is_branch & ~stall;
            hold_d      = redirect & stall;
            if (redirect) begin
                pc_d = d_nextpc;
            end else if (!stall) begin
                pc_d = pc_predicted;
            end
            if (redirect && cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Table write port: INIT clears one entry per cycle, RUN trains the
    // entry of the resolved branch. Targets change only on taken outcomes.
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = upd_idx;
        wr_valid  = 1'b1;
        wr_ctr    = ctr_q[upd_idx];
        wr_tgt_en = 1'b0;
        wr_tgt    = d_nextpc;
        if (state_q == INIT) begin
            wr_en     = 1'b1;
            wr_idx    = idx_q;
            wr_valid  = 1'b0;
            wr_ctr    = 2'd1;
            wr_tgt_en = 1'b1;
            wr_tgt    = 13'd0;
        end else if (upd_en) begin
            wr_en     = 1'b1;
            wr_tgt_en = d_taken;
            if (d_taken) begin
                if (ctr_q[upd_idx] != 2'd3) begin
                    wr_ctr = ctr_q[upd_idx] + 2'd1;
                end
            end else begin
                if (ctr_q[upd_idx] != 2'd0) begin
                    wr_ctr = ctr_q[upd_idx] - 2'd1;
                end
            end
        end
    end

    // Control registers; reset restarts the table clear from index 0 and
    // discards anything the datapath wanted to do this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            idx_q   <= '0;
            pc_q    <= 13'd0;
            cnt_q   <= 16'd0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    // Table storage has no reset of its own; the INIT sweep that follows
    // every reset clears it.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            valid_q[wr_idx] <= wr_valid;
            ctr_q[wr_idx]   <= wr_ctr;
            if (wr_tgt_en) begin
                tgt_q[wr_idx] <= wr_tgt;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl
// Self-checking bench for fetch_pc_ctrl. Each scenario task drives its own
// stimulus and compares DUT outputs against expectations derived from the
// intended behaviour; PC/prediction sequences go through a scoreboard queue.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        d_valid;
    logic [12:0] d_pc;
    logic [12:0] d_nextpc;
    logic        d_fail_predict;
    logic        d_is_branch;
    logic        d_taken;
    logic [12:0] pc;
    logic [12:0] pc_predicted;
    logic        fetch_valid;
    logic        flush;
    logic [15:0] mispredict_cnt;

    int total = 0;
    int bad   = 0;
    int unsigned exp_cnt = 0;

    typedef struct {
        logic [12:0] pc;
        logic [12:0] pred;
        logic        fv;
    } exp_t;

    exp_t sb[$];

    fetch_pc_ctrl #(.BHT_IDX(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .d_valid        (d_valid),
        .d_pc           (d_pc),
        .d_nextpc       (d_nextpc),
        .d_fail_predict (d_fail_predict),
        .d_is_branch    (d_is_branch),
        .d_taken        (d_taken),
        .pc             (pc),
        .pc_predicted   (pc_predicted),
        .fetch_valid    (fetch_valid),
        .flush          (flush),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Every task starts and ends 1 time unit after a rising edge; inputs
    // change there and outputs are sampled on the falling edge.
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        stall          = 1'b0;
        d_valid        = 1'b0;
        d_pc           = 13'd0;
        d_nextpc       = 13'd0;
        d_fail_predict = 1'b0;
        d_is_branch    = 1'b0;
        d_taken        = 1'b0;
    endtask

    task automatic drive_redirect(input logic [12:0] target, input logic br,
                                  input logic tk, input logic [12:0] dpc);
        d_valid        = 1'b1;
        d_fail_predict = 1'b1;
        d_is_branch    = br;
        d_taken        = tk;
        d_pc           = dpc;
        d_nextpc       = target;
    endtask

    task automatic test_reset;
        exp_t e;
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        // Garbage on the decode/stall inputs must be ignored during INIT.
        stall          = 1'b1;
        d_valid        = 1'b1;
        d_fail_predict = 1'b1;
        d_is_branch    = 1'b1;
        d_taken        = 1'b1;
        d_pc           = 13'd3;
        d_nextpc       = 13'd77;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            total++;
            if (fetch_valid !== 1'b0 || flush !== 1'b0 || pc !== 13'd0 || pc_predicted !== 13'd1) begin
                bad++;
                $display("[TB] FAIL init_cycle%0d got fv=%b flush=%b pc=%0d pred=%0d exp fv=0 flush=0 pc=0 pred=1",
                         i, fetch_valid, flush, pc, pc_predicted);
            end
            cyc();
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{pc: 13'(k), pred: 13'(k + 1), fv: 1'b1});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (pc !== e.pc || pc_predicted !== e.pred || fetch_valid !== e.fv) begin
                bad++;
                $display("[TB] FAIL run_seq%0d got pc=%0d pred=%0d fv=%b exp pc=%0d pred=%0d fv=%b",
                         k, pc, pc_predicted, fetch_valid, e.pc, e.pred, e.fv);
            end
            if (k == 0) begin
                total++;
                if (mispredict_cnt !== 16'd0) begin
                    bad++;
                    $display("[TB] FAIL cnt_after_init got=%0d exp=0", mispredict_cnt);
                end
            end
            cyc();
        end
    endtask

    task automatic test_branch_train;
        drive_redirect(13'd20, 1'b1, 1'b1, 13'd5);
        @(negedge clk);
        total++;
        if (flush !== 1'b1) begin
            bad++;
            $display("[TB] FAIL flush_on_redirect got=%b exp=1", flush);
        end
        cyc();
        exp_cnt = 1;
        // JALR-style redirect back to 5 must not touch entry 5.
        drive_redirect(13'd5, 1'b0, 1'b1, 13'd5);
        @(negedge clk);
        total++;
        if (pc !== 13'd20 || mispredict_cnt !== 16'(exp_cnt) || fetch_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL redirect_target got pc=%0d cnt=%0d fv=%b exp pc=20 cnt=%0d fv=1",
                     pc, mispredict_cnt, fetch_valid, exp_cnt);
        end
        cyc();
        exp_cnt = 2;
        idle_inputs();
        @(negedge clk);
        total++;
        if (pc !== 13'd5 || pc_predicted !== 13'd20) begin
            bad++;
            $display("[TB] FAIL trained_predict got pc=%0d pred=%0d exp pc=5 pred=20", pc, pc_predicted);
        end
        cyc();
        @(negedge clk);
        total++;
        if (pc !== 13'd20) begin
            bad++;
            $display("[TB] FAIL follow_prediction got pc=%0d exp=20", pc);
        end
        cyc();
    endtask

    task automatic test_stall;
        drive_redirect(13'd7, 1'b0, 1'b0, 13'd0);
        cyc();
        exp_cnt++;
        idle_inputs();
        stall       = 1'b1;
        d_valid     = 1'b1;
        d_is_branch = 1'b1;
        d_taken     = 1'b1;
        d_pc        = 13'd7;
        d_nextpc    = 13'd30;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (pc !== 13'd7 || fetch_valid !== 1'b1 || flush !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_hold%0d got pc=%0d fv=%b flush=%b exp pc=7 fv=1 flush=0",
                         i, pc, fetch_valid, flush);
            end
            cyc();
        end
        @(negedge clk);
        total++;
        if (pc !== 13'd7 || pc_predicted !== 13'd8) begin
            bad++;
            $display("[TB] FAIL stall_no_update got pc=%0d pred=%0d exp pc=7 pred=8", pc, pc_predicted);
        end
        cyc();
        drive_redirect(13'd40, 1'b0, 1'b0, 13'd0);
        stall = 1'b1;
        @(negedge clk);
        total++;
        if (flush !== 1'b1) begin
            bad++;
            $display("[TB] FAIL stall_redirect_flush got=%b exp=1", flush);
        end
        cyc();
        exp_cnt++;
        idle_inputs();
        @(negedge clk);
        total++;
        if (pc !== 13'd40 || fetch_valid !== 1'b0 || mispredict_cnt !== 16'(exp_cnt)) begin
            bad++;
            $display("[TB] FAIL stall_redirect_bubble got pc=%0d fv=%b cnt=%0d exp pc=40 fv=0 cnt=%0d",
                     pc, fetch_valid, mispredict_cnt, exp_cnt);
        end
        cyc();
        @(negedge clk);
        total++;
        if (pc !== 13'd41 || fetch_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL after_bubble got pc=%0d fv=%b exp pc=41 fv=1", pc, fetch_valid);
        end
        cyc();
    endtask

    task automatic test_counter_decay;
        int   ctr;
        exp_t e;
        // Entry 5 holds counter 2 / target 20; one more taken pushes it to 3.
        d_valid     = 1'b1;
        d_is_branch = 1'b1;
        d_taken     = 1'b1;
        d_pc        = 13'd5;
        d_nextpc    = 13'd20;
        cyc();
        ctr = 3;
        for (int k = 0; k < 4; k++) begin
            drive_redirect(13'd5, 1'b1, 1'b0, 13'd5);
            @(negedge clk);
            total++;
            if (flush !== 1'b1) begin
                bad++;
                $display("[TB] FAIL decay_flush%0d got=%b exp=1", k, flush);
            end
            if (k > 0) begin
                // Same-cycle lookup sees the pre-update entry.
                e = sb.pop_front();
                total++;
                if (pc !== e.pc || pc_predicted !== e.pred || fetch_valid !== e.fv) begin
                    bad++;
                    $display("[TB] FAIL decay%0d got pc=%0d pred=%0d fv=%b exp pc=%0d pred=%0d fv=%b",
                             k - 1, pc, pc_predicted, fetch_valid, e.pc, e.pred, e.fv);
                end
            end
            ctr = (ctr == 0) ? 0 : ctr - 1;
            sb.push_back('{pc: 13'd5, pred: (ctr >= 2) ? 13'd20 : 13'd6, fv: 1'b1});
            cyc();
            exp_cnt++;
        end
        idle_inputs();
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (pc !== e.pc || pc_predicted !== e.pred || fetch_valid !== e.fv) begin
            bad++;
            $display("[TB] FAIL decay3 got pc=%0d pred=%0d fv=%b exp pc=%0d pred=%0d fv=%b",
                     pc, pc_predicted, fetch_valid, e.pc, e.pred, e.fv);
        end
        total++;
        if (mispredict_cnt !== 16'(exp_cnt)) begin
            bad++;
            $display("[TB] FAIL decay_cnt got=%0d exp=%0d", mispredict_cnt, exp_cnt);
        end
        cyc();
    endtask

    task automatic test_wrap;
        drive_redirect(13'd8191, 1'b0, 1'b0, 13'd0);
        cyc();
        exp_cnt++;
        idle_inputs();
        @(negedge clk);
        total++;
        if (pc !== 13'd8191 || pc_predicted !== 13'd0) begin
            bad++;
            $display("[TB] FAIL pc_wrap_predict got pc=%0d pred=%0d exp pc=8191 pred=0", pc, pc_predicted);
        end
        cyc();
        @(negedge clk);
        total++;
        if (pc !== 13'd0) begin
            bad++;
            $display("[TB] FAIL pc_wrap got=%0d exp=0", pc);
        end
        cyc();
    endtask

    task automatic test_saturation;
        int n;
        n = 65534 - int'(exp_cnt);
        drive_redirect(13'd0, 1'b0, 1'b0, 13'd0);
        repeat (n) cyc();
        @(negedge clk);
        total++;
        if (mispredict_cnt !== 16'hFFFE) begin
            bad++;
            $display("[TB] FAIL cnt_near_sat got=%h exp=fffe", mispredict_cnt);
        end
        cyc();
        @(negedge clk);
        total++;
        if (mispredict_cnt !== 16'hFFFF) begin
            bad++;
            $display("[TB] FAIL cnt_sat got=%h exp=ffff", mispredict_cnt);
        end
        cyc();
        cyc();
        @(negedge clk);
        total++;
        if (mispredict_cnt !== 16'hFFFF) begin
            bad++;
            $display("[TB] FAIL cnt_sat_hold got=%h exp=ffff", mispredict_cnt);
        end
        idle_inputs();
        cyc();
        exp_cnt = 65535;
    endtask

    task automatic test_reset_mid_redirect;
        // Entry 5 decayed to 0; two taken updates bring it back to 2.
        d_valid     = 1'b1;
        d_is_branch = 1'b1;
        d_taken     = 1'b1;
        d_pc        = 13'd5;
        d_nextpc    = 13'd20;
        cyc();
        cyc();
        drive_redirect(13'd5, 1'b0, 1'b0, 13'd0);
        cyc();
        idle_inputs();
        @(negedge clk);
        total++;
        if (pc !== 13'd5 || pc_predicted !== 13'd20 || mispredict_cnt !== 16'hFFFF) begin
            bad++;
            $display("[TB] FAIL retrained got pc=%0d pred=%0d cnt=%h exp pc=5 pred=20 cnt=ffff",
                     pc, pc_predicted, mispredict_cnt);
        end
        cyc();
        drive_redirect(13'd100, 1'b1, 1'b1, 13'd9);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (flush !== 1'b0 || fetch_valid !== 1'b0 || pc_predicted !== 13'd1) begin
            bad++;
            $display("[TB] FAIL during_reset got flush=%b fv=%b pred=%0d exp flush=0 fv=0 pred=1",
                     flush, fetch_valid, pc_predicted);
        end
        cyc();
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) begin
                total++;
                if (pc !== 13'd0 || mispredict_cnt !== 16'd0) begin
                    bad++;
                    $display("[TB] FAIL reset_discard got pc=%0d cnt=%0d exp pc=0 cnt=0", pc, mispredict_cnt);
                end
            end
            total++;
            if (fetch_valid !== 1'b0 || flush !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reinit%0d got fv=%b flush=%b exp fv=0 flush=0", i, fetch_valid, flush);
            end
            cyc();
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (pc !== 13'(k) || fetch_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL rerun%0d got pc=%0d fv=%b exp pc=%0d fv=1", k, pc, fetch_valid, k);
            end
            if (k == 5) begin
                total++;
                if (pc_predicted !== 13'd6) begin
                    bad++;
                    $display("[TB] FAIL entry_cleared got pred=%0d exp=6", pc_predicted);
                end
            end
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_branch_train();
        test_stall();
        test_counter_decay();
        test_wrap();
        test_saturation();
        test_reset_mid_redirect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
